// File: rtl/adder_pkg.sv
// Shared defaults and saturation constants for the chunked saturating adder.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
  localparam int MAX_W     = 64;

  function automatic logic [MAX_W-1:0] most_pos(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] most_neg(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_adder_pipe_if.sv
// Operand/result handshake bundle for sat_adder_pipe.
interface sat_adder_pipe_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                    InValid;
  logic                    InReady;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic                    Sub;
  logic                    OutValid;
  logic                    OutReady;
  logic signed [WIDTH-1:0] Sum;
  logic                    Overflow;

  modport master (
    output InValid, A, B, Sub, OutReady,
    input  InReady, OutValid, Sum, Overflow
  );

  modport slave (
    input  InValid, A, B, Sub, OutReady,
    output InReady, OutValid, Sum, Overflow
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder exposing the carry into its top bit.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carry_o = c[CHUNK];
  assign cmsb_o  = c[CHUNK-1];

endmodule

// File: rtl/sat_adder_pipe.sv
// Signed add/subtract pipelined CHUNK bits per stage, with optional saturation.
module sat_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int SAT   = 1
) (
  input logic             clk,
  input logic             rst_n,
  sat_adder_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;

  // a/b hold the not-yet-added chunks, shifted down so chunk k sits at bit 0.
  typedef struct packed {
    logic             vld;
    logic             sub;
    logic             asgn;
    logic             cy;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [MAX_W-1:0] full;
    full = neg ? most_neg(WIDTH) : most_pos(WIDTH);
    return full[WIDTH-1:0];
  endfunction

  stage_t st_q [STAGES];
  stage_t in_d;
  logic   adv;

  assign adv          = !st_q[STAGES-1].vld || bus.OutReady;
  assign bus.InReady  = adv;
  assign bus.OutValid = st_q[STAGES-1].vld;
  assign bus.Sum      = st_q[STAGES-1].sum;
  assign bus.Overflow = st_q[STAGES-1].ovf;

  always_comb begin
    in_d      = '0;
    in_d.vld  = bus.InValid && adv;
    in_d.sub  = bus.Sub;
    in_d.asgn = bus.A[WIDTH-1];
    in_d.cy   = bus.Sub;
    in_d.a    = bus.A;
    in_d.b    = bus.B;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           prev;
    stage_t           st_d;
    logic [CHUNK-1:0] c_sum;
    logic             c_out;
    logic             c_msb;

    if (k == 0) begin : g_head
      assign prev = in_d;
    end else begin : g_body
      assign prev = st_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i     (prev.a[CHUNK-1:0]),
      .b_i     (prev.b[CHUNK-1:0] ^ {CHUNK{prev.sub}}),
      .cin_i   (prev.cy),
      .sum_o   (c_sum),
      .carry_o (c_out),
      .cmsb_o  (c_msb)
    );

    // ovf is only meaningful once the top chunk has been added in the last stage.
    always_comb begin
      st_d                       = prev;
      st_d.a                     = prev.a >> CHUNK;
      st_d.b                     = prev.b >> CHUNK;
      st_d.cy                    = c_out;
      st_d.ovf                   = c_msb ^ c_out;
      st_d.sum[k*CHUNK +: CHUNK] = c_sum;
      if (k == STAGES - 1 && SAT != 0 && st_d.ovf) st_d.sum = sat_value(prev.asgn);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q[k].vld <= 1'b0;
        if (k == STAGES - 1) begin
          st_q[k].sum <= '0;
          st_q[k].ovf <= 1'b0;
        end
      end else if (adv) begin
        st_q[k] <= st_d;
      end
    end
  end

endmodule
